// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
// Provides the operation codes, FSM state encoding and the counter-width helper.
// Pure declarations: no timing or backpressure of its own.
package mdu_pkg;

   // Operation select, as presented on MduOp
   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_RSVD  = 3'd7
   } mdu_op_e;

   // Controller states: wait for work, iterate, apply sign fix-up
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   // Width of the iteration counter for a given operand width
   function automatic int mdu_cnt_width(input int data_bits);
      return $clog2(data_bits);
   endfunction

endpackage

// File: rtl/mul_div_unit_cond_neg.sv
// Conditional two's-complement negate: out = en ? -in : in.
// Purely combinational, zero latency.
// No flow control; output follows inputs continuously.
module mdu_cond_neg #(
   parameter int W = 32
) (
   input  logic         en,
   input  logic [W-1:0] in_dat,
   output logic [W-1:0] out_dat
);

   // Negate by invert-and-increment when enabled
   always_comb begin
      out_dat = in_dat;
      if (en) begin
         out_dat = (~in_dat) + W'(1);
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Latency: mul/div results land DATA_BITS+2 edges after Start; MTHI/MTLO one edge.
// Busy is high while an operation is in flight; Start is ignored while Busy.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] AluA,
   input  logic [DATA_BITS-1:0] AluB,
   input  logic [2:0]           MduOp,
   input  logic                 Start,
   output logic                 Busy,
   output logic                 Done,
   output logic [DATA_BITS-1:0] Hi,
   output logic [DATA_BITS-1:0] Lo
);

   localparam int N     = DATA_BITS;
   localparam int CNT_W = mdu_cnt_width(DATA_BITS);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Multiply: full product accumulator, multiplier shifted out of the bottom.
   // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
   logic [2*N-1:0]   acc_q, acc_d;
   // Partial remainder; the shifted-in bit forms the (N+1)-bit working value
   logic [N-1:0]     rem_q, rem_d;
   logic [N-1:0]     a_mag_q, a_mag_d;
   logic [N-1:0]     b_mag_q, b_mag_d;
   logic [N-1:0]     raw_a_q, raw_a_d;
   logic             is_div_q, is_div_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             div_zero_q, div_zero_d;
   logic [N-1:0]     hi_q, hi_d;
   logic [N-1:0]     lo_q, lo_d;
   logic             done_q, done_d;

   // ------------------------------------------------------------------
   // Operand decode and magnitude conversion
   // ------------------------------------------------------------------
   mdu_op_e    op;
   logic       op_signed;
   logic       op_arith;
   logic       op_is_div;
   logic [N-1:0] a_mag_in;
   logic [N-1:0] b_mag_in;

   assign op = mdu_op_e'(MduOp);

   // Classify the requested operation
   always_comb begin
      op_signed = 1'b0;
      op_arith  = 1'b0;
      op_is_div = 1'b0;
      case (op)
         MDU_MULT:  begin op_arith = 1'b1; op_signed = 1'b1; end
         MDU_MULTU: begin op_arith = 1'b1; end
         MDU_DIV:   begin op_arith = 1'b1; op_signed = 1'b1; op_is_div = 1'b1; end
         MDU_DIVU:  begin op_arith = 1'b1; op_is_div = 1'b1; end
         default:   begin op_arith = 1'b0; end
      endcase
   end

   mdu_cond_neg #(.W(N)) u_neg_a (
      .en      (op_signed & AluA[N-1]),
      .in_dat  (AluA),
      .out_dat (a_mag_in)
   );

   mdu_cond_neg #(.W(N)) u_neg_b (
      .en      (op_signed & AluB[N-1]),
      .in_dat  (AluB),
      .out_dat (b_mag_in)
   );

   // ------------------------------------------------------------------
   // Result sign fix-up (used in FIX)
   // ------------------------------------------------------------------
   logic [2*N-1:0] prod_fix;
   logic [N-1:0]   quo_fix;
   logic [N-1:0]   rem_fix;

   mdu_cond_neg #(.W(2*N)) u_neg_prod (
      .en      (sign_a_q ^ sign_b_q),
      .in_dat  (acc_q),
      .out_dat (prod_fix)
   );

   mdu_cond_neg #(.W(N)) u_neg_quo (
      .en      (sign_a_q ^ sign_b_q),
      .in_dat  (acc_q[N-1:0]),
      .out_dat (quo_fix)
   );

   // Remainder carries the sign of the dividend
   mdu_cond_neg #(.W(N)) u_neg_rem (
      .en      (sign_a_q),
      .in_dat  (rem_q),
      .out_dat (rem_fix)
   );

   // ------------------------------------------------------------------
   // Per-iteration datapath
   // ------------------------------------------------------------------
   logic [N:0] mul_sum;
   logic [N:0] div_shift;
   logic [N:0] div_diff;

   // One shift-add step and one restoring-divide step, selected in the FSM
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_mag_q} : {(N+1){1'b0}});
      div_shift = {rem_q, acc_q[N-1]};
      div_diff  = div_shift - {1'b0, b_mag_q};
   end

   // ------------------------------------------------------------------
   // Controller: next state, datapath and HI/LO updates
   // ------------------------------------------------------------------
   // Next-state and register-update logic for IDLE/RUN/FIX
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      a_mag_d    = a_mag_q;
      b_mag_d    = b_mag_q;
      raw_a_d    = raw_a_q;
      is_div_d   = is_div_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (op_arith) begin
                  is_div_d   = op_is_div;
                  sign_a_d   = op_signed & AluA[N-1];
                  sign_b_d   = op_signed & AluB[N-1];
                  a_mag_d    = a_mag_in;
                  b_mag_d    = b_mag_in;
                  raw_a_d    = AluA;
                  div_zero_d = (AluB == {N{1'b0}});
                  // Multiply shifts the multiplier out of the low half;
                  // divide shifts the dividend out of it.
                  acc_d      = {{N{1'b0}}, op_is_div ? a_mag_in : b_mag_in};
                  rem_d      = {N{1'b0}};
                  cnt_d      = CNT_W'(N - 1);
                  state_d    = ST_RUN;
               end else if (op == MDU_MTHI) begin
                  hi_d   = AluA;
                  done_d = 1'b1;
               end else if (op == MDU_MTLO) begin
                  lo_d   = AluA;
                  done_d = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (is_div_q) begin
               // Subtract succeeds when the (N+1)-bit difference is non-negative
               acc_d = {acc_q[2*N-1:N], acc_q[N-2:0], ~div_diff[N]};
               rem_d = div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0];
            end else begin
               acc_d = {mul_sum, acc_q[N-1:1]};
            end
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_FIX: begin
            if (is_div_q) begin
               if (div_zero_q) begin
                  // Divide by zero skips sign fix-up entirely
                  lo_d = {N{1'b1}};
                  hi_d = raw_a_q;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end else begin
               hi_d = prod_fix[2*N-1:N];
               lo_d = prod_fix[N-1:0];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         acc_q      <= {(2*N){1'b0}};
         rem_q      <= {N{1'b0}};
         a_mag_q    <= {N{1'b0}};
         b_mag_q    <= {N{1'b0}};
         raw_a_q    <= {N{1'b0}};
         is_div_q   <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= {N{1'b0}};
         lo_q       <= {N{1'b0}};
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         a_mag_q    <= a_mag_d;
         b_mag_q    <= b_mag_d;
         raw_a_q    <= raw_a_d;
         is_div_q   <= is_div_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign Busy = (state_q != ST_IDLE);
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (DATA_BITS=32).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every wait on Done is bounded; a timeout counts as an error.
module tb_mul_div_unit;

   logic        clk;
   logic        rst;
   logic [31:0] AluA;
   logic [31:0] AluB;
   logic [2:0]  MduOp;
   logic        Start;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   mul_div_unit #(.DATA_BITS(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .AluA  (AluA),
      .AluB  (AluB),
      .MduOp (MduOp),
      .Start (Start),
      .Busy  (Busy),
      .Done  (Done),
      .Hi    (Hi),
      .Lo    (Lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch an op and wait for Done. lat = edges from Start edge to Done
   // (-1 on timeout); busy_bad counts cycles where Busy/Done disagreed with
   // the expected shape (Busy high before Done, never both high).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_bad);
      lat      = -1;
      busy_bad = 0;
      @(negedge clk);
      MduOp = op; AluA = a; AluB = b; Start = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         @(negedge clk);
         Start = 1'b0;
         if (Busy && Done) busy_bad++;
         if (Done) begin
            lat = n;
            break;
         end
         if (!Busy) busy_bad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: Busy=%b Done=%b, required 0 0", Busy, Done);
      end
      checks++;
      if (Hi !== 32'h0 || Lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_hilo: Hi=%h Lo=%h, required 0 0", Hi, Lo);
      end
      rst = 1'b0;
   endtask

   task automatic test_mult_signed();
      int lat, bb;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bb);
      checks++;
      if (lat !== 34) begin
         errors++;
         $display("FAIL mult_latency: got %0d edges, required 34", lat);
      end
      checks++;
      if (bb !== 0) begin
         errors++;
         $display("FAIL mult_busy_shape: %0d bad cycles, required 0", bb);
      end
      checks++;
      if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL mult_neg3x7: Hi=%h Lo=%h, required ffffffff ffffffeb", Hi, Lo);
      end
      @(negedge clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL mult_done_pulse: Done=%b Busy=%b, required 0 0", Done, Busy);
      end
   endtask

   task automatic test_multu_ignore_start();
      int lat, done_cnt;
      lat = -1;
      done_cnt = 0;
      @(negedge clk);
      MduOp = OP_MULTU; AluA = 32'hFFFF_FFFF; AluB = 32'hFFFF_FFFF; Start = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         @(negedge clk);
         Start = 1'b0;
         // Inject a DIVU and scramble operands mid-RUN
         if (n == 10) begin
            MduOp = OP_DIVU; AluA = 32'd100; AluB = 32'd3; Start = 1'b1;
         end
         if (Done) begin
            lat = n;
            break;
         end
      end
      Start = 1'b0;
      checks++;
      if (lat !== 34) begin
         errors++;
         $display("FAIL multu_latency: got %0d edges, required 34", lat);
      end
      checks++;
      if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_max: Hi=%h Lo=%h, required fffffffe 00000001", Hi, Lo);
      end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (Done || Busy) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL multu_ignored_start: %0d extra Busy/Done cycles, required 0", done_cnt);
      end
      checks++;
      if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_hold: Hi=%h Lo=%h, required fffffffe 00000001", Hi, Lo);
      end
   endtask

   task automatic test_div();
      int lat, bb;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bb);
      checks++;
      if (lat !== 34 || bb !== 0) begin
         errors++;
         $display("FAIL div_timing: lat=%0d bad=%0d, required 34 0", lat, bb);
      end
      checks++;
      if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_neg7_2: Hi=%h Lo=%h, required ffffffff fffffffd", Hi, Lo);
      end
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb);
      checks++;
      if (Lo !== 32'h8000_0000 || Hi !== 32'h0 || lat !== 34) begin
         errors++;
         $display("FAIL div_overflow: Hi=%h Lo=%h lat=%0d, required 00000000 80000000 34", Hi, Lo, lat);
      end
      run_op(OP_DIVU, 32'd100, 32'd7, lat, bb);
      checks++;
      if (Lo !== 32'd14 || Hi !== 32'd2) begin
         errors++;
         $display("FAIL divu_100_7: Hi=%h Lo=%h, required 00000002 0000000e", Hi, Lo);
      end
   endtask

   task automatic test_div_zero();
      int lat, bb;
      run_op(OP_DIVU, 32'd100, 32'd0, lat, bb);
      checks++;
      if (Lo !== 32'hFFFF_FFFF || Hi !== 32'h0000_0064 || lat !== 34) begin
         errors++;
         $display("FAIL divu_by_zero: Hi=%h Lo=%h lat=%0d, required 00000064 ffffffff 34", Hi, Lo, lat);
      end
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, bb);
      checks++;
      if (Lo !== 32'hFFFF_FFFF || Hi !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL div_by_zero: Hi=%h Lo=%h, required fffffff9 ffffffff", Hi, Lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] lo_before;
      lo_before = Lo;
      @(negedge clk);
      MduOp = OP_MTHI; AluA = 32'h1234_5678; Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (Hi !== 32'h1234_5678 || Lo !== lo_before || Done !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL mthi: Hi=%h Lo=%h Done=%b Busy=%b, required 12345678 %h 1 0", Hi, Lo, Done, Busy, lo_before);
      end
      MduOp = OP_MTLO; AluA = 32'h9ABC_DEF0; Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0; MduOp = OP_NONE;
      checks++;
      if (Lo !== 32'h9ABC_DEF0 || Hi !== 32'h1234_5678 || Done !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL mtlo: Hi=%h Lo=%h Done=%b Busy=%b, required 12345678 9abcdef0 1 0", Hi, Lo, Done, Busy);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL mtx_done_clear: Done=%b Busy=%b, required 0 0", Done, Busy);
      end
      // NONE and reserved opcodes must leave HI/LO alone
      MduOp = 3'd7; AluA = 32'hDEAD_BEEF; Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      MduOp = OP_NONE; Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0;
      checks++;
      if (Hi !== 32'h1234_5678 || Lo !== 32'h9ABC_DEF0 || Done !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL none_rsvd: Hi=%h Lo=%h Done=%b Busy=%b, required 12345678 9abcdef0 0 0", Hi, Lo, Done, Busy);
      end
   endtask

   task automatic test_reset_mid_op();
      int done_cnt, lat, bb;
      done_cnt = 0;
      @(negedge clk);
      MduOp = OP_MULT; AluA = 32'd5; AluB = 32'd6; Start = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         @(negedge clk);
         Start = 1'b0;
      end
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL midop_busy: Busy=%b, required 1", Busy);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
         errors++;
         $display("FAIL midop_reset: Busy=%b Done=%b Hi=%h Lo=%h, required 0 0 0 0", Busy, Done, Hi, Lo);
      end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (Done || Busy) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL midop_no_done: %0d Busy/Done cycles after reset, required 0", done_cnt);
      end
      run_op(OP_MULT, 32'd5, 32'd6, lat, bb);
      checks++;
      if (Lo !== 32'd30 || Hi !== 32'd0 || lat !== 34 || bb !== 0) begin
         errors++;
         $display("FAIL mult_after_reset: Hi=%h Lo=%h lat=%0d bad=%0d, required 0 1e 34 0", Hi, Lo, lat, bb);
      end
   endtask

   initial begin
      rst = 1'b1; AluA = '0; AluB = '0; MduOp = OP_NONE; Start = 1'b0;
      test_reset();
      test_mult_signed();
      test_multu_ignore_start();
      test_div();
      test_div_zero();
      test_mthi_mtlo();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
